delay_line_ctrl: RTL and testbench

- Programmable-latency pipeline for a WIDTH-bit sample stream: a chain of MAX_DELAY register stages plus a tap select, owned by a small reconfiguration controller.
- The controller accepts delay-change requests on a valid/ready config port.
- Before moving the output tap it drains in-flight samples at the old tap, so no sample is ever lost, duplicated or emitted at the wrong latency.
- Sits between a sample source and any consumer that needs a runtime-adjustable alignment delay.

---
 rtl/delay_line_ctrl_pkg.sv | 20 ++
 rtl/delay_stage.sv | 28 ++
 rtl/delay_line_ctrl.sv | 122 ++++++++++++
 tb/tb_delay_line_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/delay_line_ctrl_pkg.sv
// Shared definitions for the programmable delay line.
//   - default sample width and stage count
//   - controller state encoding (RUN / DRAIN / SWITCH)
//   - dw_of(): width of a field able to hold 0..max_delay
package delay_line_ctrl_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_DELAY = 3;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] SWITCH = 2'd2;

    function automatic int dw_of(input int max_delay);
        return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One register stage of the delay line.
//   clk, resetn  : clock, synchronous active-low reset
//   clr          : synchronous clear of the valid bit (data is kept)
//   prev_data/prev_valid : sample arriving from the previous stage
//   data/valid   : registered sample held by this stage
module delay_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            data  <= prev_data;
            valid <= prev_valid & ~clr;
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Programmable-latency sample pipeline with a drain-before-switch controller.
//   clk, resetn          : clock, synchronous active-low reset
//   in_valid/in_ready/in_data    : sample input (stalled while reconfiguring)
//   out_valid/out_data   : sample from the selected tap, no backpressure
//   cfg_valid/cfg_ready/cfg_delay: delay-change request (clamped to MAX_DELAY)
//   cur_delay            : delay currently applied to the tap
//   busy                 : controller is draining or switching
module delay_line_ctrl
    import delay_line_ctrl_pkg::*;
#(
    parameter  int WIDTH       = DEF_WIDTH,
    parameter  int MAX_DELAY   = DEF_MAX_DELAY,
    parameter  int RESET_DELAY = 0,
    localparam int DW          = dw_of(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DW-1:0]    cfg_delay,
    output logic [DW-1:0]    cur_delay,
    output logic             busy
);

    state_t                          state;
    logic [DW-1:0]                   cnt;
    logic [DW-1:0]                   pend;
    logic [DW-1:0]                   cfg_clamped;
    logic                            accept_in;
    logic                            clr;
    logic [MAX_DELAY-1:0][WIDTH-1:0] prev_data;
    logic [MAX_DELAY-1:0]            prev_valid;
    logic [MAX_DELAY-1:0][WIDTH-1:0] stage_data;
    logic [MAX_DELAY-1:0]            stage_valid;

    assign in_ready    = (state == RUN);
    assign cfg_ready   = (state == RUN);
    assign busy        = (state != RUN);
    assign accept_in   = in_valid & in_ready;
    assign clr         = (state == SWITCH);
    assign cfg_clamped = (cfg_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_delay;

    // Register chain: stage 0 is fed from the input, stage k from stage k-1
    for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign prev_data[k]  = in_data;
            assign prev_valid[k] = accept_in;
        end else begin : g_rest
            assign prev_data[k]  = stage_data[k-1];
            assign prev_valid[k] = stage_valid[k-1];
        end

        delay_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .resetn     (resetn),
            .clr        (clr),
            .prev_data  (prev_data[k]),
            .prev_valid (prev_valid[k]),
            .data       (stage_data[k]),
            .valid      (stage_valid[k])
        );
    end

    // Tap mux: delay 0 is a combinational bypass of the input
    always_comb begin
        out_data  = in_data;
        out_valid = accept_in;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (cur_delay == DW'(k)) begin
                out_data  = stage_data[k-1];
                out_valid = stage_valid[k-1];
            end
        end
        if (state == SWITCH)
            out_valid = 1'b0;
    end

    // Reconfiguration controller. DRAIN lasts cur_delay cycles so the last
    // sample accepted before the request leaves at the old latency; SWITCH
    // then moves the tap and flushes the (now stale) stage valids.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= RUN;
            cur_delay <= DW'(RESET_DELAY);
            cnt       <= '0;
            pend      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (cfg_valid) begin
                        pend <= cfg_clamped;
                        if (cfg_clamped != cur_delay) begin
                            if (cur_delay == '0) begin
                                state <= SWITCH;
                            end else begin
                                cnt   <= cur_delay - 1'b1;
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0)
                        state <= SWITCH;
                    else
                        cnt <= cnt - 1'b1;
                end
                SWITCH: begin
                    cur_delay <= pend;
                    state     <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
module tb_delay_line_ctrl;

    localparam int WIDTH     = 8;
    localparam int MAX_DELAY = 3;
    localparam int DW        = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DW-1:0]    cfg_delay;
    logic [DW-1:0]    cur_delay;
    logic             busy;

    delay_line_ctrl #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .RESET_DELAY(0)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_delay (cfg_delay),
        .cur_delay (cur_delay),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: expected output per cycle, keyed by absolute cycle
    logic [WIDTH-1:0] sched [int];
    int m_cur  = 0;   // delay in effect
    int m_blk  = 0;   // cycles still blocked (old_delay + 1 after a change)
    int m_pend = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance.
    task automatic tick();
        bit cacc;
        int nd;
        cacc = 1'b0;
        #3;
        if (resetn) begin
            chk("in_ready",  32'(in_ready),  32'(m_blk == 0));
            chk("cfg_ready", 32'(cfg_ready), 32'(m_blk == 0));
            chk("busy",      32'(busy),      32'(m_blk != 0));
            chk("cur_delay", 32'(cur_delay), 32'(m_cur));
            if (in_valid && m_blk == 0)
                sched[cyc + m_cur] = in_data;
            if (sched.exists(cyc)) begin
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("out_data",  32'(out_data),  32'(sched[cyc]));
                sched.delete(cyc);
            end else begin
                chk("out_valid", 32'(out_valid), 32'd0);
            end
            cacc = cfg_valid && (m_blk == 0);
            if (m_blk > 0) begin
                m_blk--;
                if (m_blk == 0) m_cur = m_pend;
            end else if (cacc) begin
                nd = (int'(cfg_delay) > MAX_DELAY) ? MAX_DELAY : int'(cfg_delay);
                if (nd != m_cur) begin
                    m_blk  = m_cur + 1;
                    m_pend = nd;
                end
            end
        end else begin
            sched.delete();
            m_cur = 0;
            m_blk = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cacc) cfg_valid = 1'b0;
    endtask

    task automatic request(input int d);
        cfg_valid = 1'b1;
        cfg_delay = DW'(d);
        tick();
        while (m_blk > 0) tick();
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_data = '0; cfg_valid = 1'b0; cfg_delay = '0;
        @(posedge clk); #1;
        tick(); tick();
        resetn = 1'b1;

        // Delay 0 streaming
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        while (cyc < 10) tick();

        // 0 -> 2 with streaming input
        in_valid = 1'b1; in_data = 8'h5C;
        cfg_valid = 1'b1; cfg_delay = 2'd2;
        tick();
        in_data = 8'h66; tick();
        in_data = 8'hA5; tick();
        for (int i = 0; i < 4; i++) begin in_data = 8'($urandom); tick(); end

        // Same-value request: no stall
        cfg_valid = 1'b1; cfg_delay = 2'd2;
        for (int i = 0; i < 4; i++) begin in_data = 8'($urandom); tick(); end

        // 2 -> 3, then 3 -> 1 with 0x01..0x04 in flight
        request(3);
        in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        in_data = 8'h03; tick();
        in_data = 8'h04; cfg_valid = 1'b1; cfg_delay = 2'd1; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Bubbles at delay 3; request held at 3 while busy must be ignored
        in_valid = 1'b0;
        request(3);
        in_valid = 1'b1; in_data = 8'hB1; tick();
        in_valid = 1'b0; in_data = 8'hEE; tick();
        in_valid = 1'b1; in_data = 8'hB3; tick();
        in_valid = 1'b1; in_data = 8'hB4; tick();
        in_valid = 1'b0;
        cfg_valid = 1'b1; cfg_delay = 2'd0; tick();
        while (m_blk > 0) begin cfg_valid = 1'b1; cfg_delay = 2'd3; tick(); end
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset in the middle of a 3 -> 0 drain
        request(3);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin in_data = 8'($urandom); tick(); end
        cfg_valid = 1'b1; cfg_delay = 2'd0; tick();
        in_valid = 1'b0; tick();
        resetn = 1'b0; tick();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Random traffic with occasional held requests
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = 8'($urandom);
            if (!cfg_valid && ($urandom % 12) == 0) begin
                cfg_valid = 1'b1;
                cfg_delay = DW'($urandom);
            end
            if (($urandom % 150) == 0) resetn = 1'b0;
            tick();
            resetn = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
